// File: rtl/flow_pkg.sv
// rtl/flow_pkg.sv - shared constants and parameter legality check for the credit flow stage
package flow_pkg;

    localparam int CREDIT_WIDTH_DFLT = 8;

    function automatic bit params_ok(input int depth, input int batch,
                                     input int timeout, input int credit_width);
        bit ok;
        ok = 1'b1;
        if (depth < 2 || (depth & (depth - 1)) != 0) ok = 1'b0;
        if (batch < 1 || batch > depth) ok = 1'b0;
        if (timeout < 1) ok = 1'b0;
        // Level and credit outputs must be able to represent a completely full buffer.
        if (credit_width < 31 && (1 << credit_width) <= depth) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/credit_rx_buffer_if.sv
// rtl/credit_rx_buffer_if.sv - AXI-Stream beat bundle with master/slave views
interface credit_rx_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word fall-through FIFO with wrap-bit pointers
module sync_fifo_fwft
    import flow_pkg::*;
#(
    parameter int WIDTH       = 33,
    parameter int DEPTH       = 16,
    parameter int LEVEL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [LEVEL_WIDTH-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    used;
    logic             do_wr;
    logic             do_rd;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign used  = wr_ptr_q - rd_ptr_q;
    assign level = LEVEL_WIDTH'(used);

    // Head is forced to zero while empty so the output is defined without clearing the array.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_wr);
        rd_ptr_d = rd_ptr_q + PW'(do_rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/credit_rx_buffer.sv
// rtl/credit_rx_buffer.sv - receive FIFO that returns drained beats to the sender as batched credits
module credit_rx_buffer
    import flow_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int CREDIT_WIDTH   = CREDIT_WIDTH_DFLT,
    parameter int DEPTH          = 16,
    parameter int RETURN_BATCH   = 4,
    parameter int RETURN_TIMEOUT = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    credit_rx_buffer_if.slave       s_axis,
    credit_rx_buffer_if.master      m_axis,
    output logic [CREDIT_WIDTH-1:0] o_credit_add,
    output logic [CREDIT_WIDTH-1:0] o_level,
    output logic                    o_protocol_err,
    input  logic                    i_clear_err
);
    localparam int PEND_W = $clog2(RETURN_BATCH) + 1;
    localparam int TMR_W  = $clog2(RETURN_TIMEOUT) + 1;

    if (!params_ok(DEPTH, RETURN_BATCH, RETURN_TIMEOUT, CREDIT_WIDTH)) begin : g_param_check
        $error("credit_rx_buffer: illegal DEPTH/RETURN_BATCH/RETURN_TIMEOUT/CREDIT_WIDTH");
    end

    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic [DATA_WIDTH:0]     head;

    logic [PEND_W-1:0]       pending_q, pending_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [CREDIT_WIDTH-1:0] credit_add_q, credit_add_d;
    logic                    err_q, err_d;
    logic [PEND_W-1:0]       sum;

    assign s_axis.tready = !full;
    assign m_axis.tvalid = !empty;
    assign m_axis.tdata  = head[DATA_WIDTH-1:0];
    assign m_axis.tlast  = head[DATA_WIDTH];
    assign push          = s_axis.tvalid && !full;
    assign pop           = !empty && m_axis.tready;

    sync_fifo_fwft #(
        .WIDTH       (DATA_WIDTH + 1),
        .DEPTH       (DEPTH),
        .LEVEL_WIDTH (CREDIT_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ({s_axis.tlast, s_axis.tdata}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (o_level)
    );

    // Credits accumulate per pop and flush either as a full batch or once the oldest one has aged out.
    always_comb begin
        sum          = pending_q + PEND_W'(pop);
        pending_d    = sum;
        timer_d      = '0;
        credit_add_d = '0;
        if (sum >= PEND_W'(RETURN_BATCH) ||
            (sum != '0 && timer_q == TMR_W'(RETURN_TIMEOUT - 1))) begin
            credit_add_d = CREDIT_WIDTH'(sum);
            pending_d    = '0;
        end else if (sum != '0) begin
            timer_d = timer_q + 1'b1;
        end
        err_d = (s_axis.tvalid && full) || (err_q && !i_clear_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= '0;
            timer_q      <= '0;
            credit_add_q <= '0;
            err_q        <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            timer_q      <= timer_d;
            credit_add_q <= credit_add_d;
            err_q        <= err_d;
        end
    end

    assign o_credit_add   = credit_add_q;
    assign o_protocol_err = err_q;
endmodule

// File: tb/tb_credit_rx_buffer.sv
// tb/tb_credit_rx_buffer.sv - randomized directed bench for credit_rx_buffer against a queue model
module tb_credit_rx_buffer;
    localparam int DW      = 32;
    localparam int CW      = 8;
    localparam int DEPTH   = 16;
    localparam int BATCH   = 4;
    localparam int TIMEOUT = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic [CW-1:0] credit_add;
    logic [CW-1:0] level;
    logic          perr;

    credit_rx_buffer_if #(.DATA_WIDTH(DW)) s_if ();
    credit_rx_buffer_if #(.DATA_WIDTH(DW)) m_if ();

    credit_rx_buffer #(
        .DATA_WIDTH     (DW),
        .CREDIT_WIDTH   (CW),
        .DEPTH          (DEPTH),
        .RETURN_BATCH   (BATCH),
        .RETURN_TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .o_credit_add   (credit_add),
        .o_level        (level),
        .o_protocol_err (perr),
        .i_clear_err    (clr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [DW:0] q[$];
    int          cyc = 0;
    int          pend = 0;
    int          oldest = 0;
    int          exp_credit = 0;
    bit          exp_err = 1'b0;
    int          pops_total = 0;
    int          credits_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit tv, input bit rdy, input bit c);
        s_if.tvalid = tv;
        s_if.tdata  = $urandom;
        s_if.tlast  = 1'($urandom_range(0, 1));
        m_if.tready = rdy;
        clr         = c;
    endtask

    task automatic tick();
        int lvl;
        bit push, pop;
        int sum;
        lvl = q.size();
        chk("s_tready", 64'(s_if.tready), 64'(lvl < DEPTH));
        chk("m_tvalid", 64'(m_if.tvalid), 64'(lvl > 0));
        chk("level", 64'(level), 64'(lvl));
        chk("credit_add", 64'(credit_add), 64'(exp_credit));
        chk("protocol_err", 64'(perr), 64'(exp_err));
        chk("m_tdata", 64'(m_if.tdata), (lvl > 0) ? 64'(q[0][DW-1:0]) : 64'd0);
        chk("m_tlast", 64'(m_if.tlast), (lvl > 0) ? 64'(q[0][DW]) : 64'd0);
        credits_seen += int'(credit_add);

        push    = s_if.tvalid && (lvl < DEPTH);
        pop     = (lvl > 0) && m_if.tready;
        exp_err = (s_if.tvalid && lvl == DEPTH) || (exp_err && !clr);
        if (pop) begin
            void'(q.pop_front());
            pops_total++;
            if (pend == 0) oldest = cyc;
        end
        if (push) q.push_back({s_if.tlast, s_if.tdata});

        sum = pend + int'(pop);
        if (sum >= BATCH || (sum > 0 && cyc - oldest == TIMEOUT - 1)) begin
            exp_credit = sum;
            pend       = 0;
        end else begin
            exp_credit = 0;
            pend       = sum;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        pend         = 0;
        exp_credit   = 0;
        exp_err      = 1'b0;
        pops_total   = 0;
        credits_seen = 0;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_s_tready", 64'(s_if.tready), 64'd1);
        chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_m_tdata", 64'(m_if.tdata), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_credit", 64'(credit_add), 64'd0);
        chk("rst_err", 64'(perr), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // batch return: 4 beats in, 4 back-to-back pops
        for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 1'b0); tick(); end
        for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b1, 1'b0); tick(); end
        for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b0, 1'b0); tick(); end

        // timeout return of a single credit
        drive(1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b0); tick();
        for (int i = 0; i < 40; i++) begin drive(1'b0, 1'b0, 1'b0); tick(); end

        // fill, overrun attempt, sticky error, clear, set-beats-clear
        for (int i = 0; i < 16; i++) begin drive(1'b1, 1'b0, 1'b0); tick(); end
        for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 1'b0); tick(); end
        for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b0, 1'b0); tick(); end
        drive(1'b0, 1'b0, 1'b1); tick();
        drive(1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1); tick();
        drive(1'b0, 1'b0, 1'b1); tick();

        // drain to level 8, then 20 cycles of simultaneous push and pop
        for (int i = 0; i < 8; i++) begin drive(1'b0, 1'b1, 1'b0); tick(); end
        for (int i = 0; i < 20; i++) begin drive(1'b1, 1'b1, 1'b0); tick(); end
        for (int i = 0; i < 10; i++) begin drive(1'b0, 1'b1, 1'b0); tick(); end
        for (int i = 0; i < 40; i++) begin drive(1'b0, 1'b0, 1'b0); tick(); end
        chk("credit_total_a", 64'(credits_seen), 64'(pops_total));

        // push into empty FIFO with consumer ready
        drive(1'b1, 1'b1, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b1, 1'b0); tick(); end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 15) == 0));
            tick();
        end
        for (int i = 0; i < 60; i++) begin drive(1'b0, 1'b1, 1'b1); tick(); end
        chk("credit_total_b", 64'(credits_seen), 64'(pops_total));

        // reset with level 5 and 2 credits pending
        for (int i = 0; i < 7; i++) begin drive(1'b1, 1'b0, 1'b0); tick(); end
        for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b1, 1'b0); tick(); end
        drive(1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_level", 64'(level), 64'd0);
        chk("midrst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("midrst_credit", 64'(credit_add), 64'd0);
        chk("midrst_s_tready", 64'(s_if.tready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 40; i++) begin drive(1'b0, 1'b0, 1'b0); tick(); end
        chk("postrst_credit_total", 64'(credits_seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/credit_rx_buffer.md
# credit_rx_buffer

Receive-side partner of the credit-based flow-control stage. It sits directly downstream of the credit-gated AXI-Stream link and buffers every beat the sender pushes in a DEPTH-entry FIFO. As the consumer drains beats it returns them to the sender as batched credit pulses that drive the sender's credit-add input. DEPTH must equal the sender's initial credit count, so a compliant sender can never overrun the buffer.

## Interface
Parameters:
- DATA_WIDTH, 32: beat width.
- CREDIT_WIDTH, 8: width of credit return and level outputs; must satisfy 2^CREDIT_WIDTH > DEPTH.
- DEPTH, 16: FIFO entries; power of two, ≥2; equals the sender's initial credit count.
- RETURN_BATCH, 4: drained beats that force an immediate credit return; 1 ≤ RETURN_BATCH ≤ DEPTH.
- RETURN_TIMEOUT, 32: cycles with pending credits (and no return) before a forced partial return; ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  upstream beat.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tlast  in  1  end of packet.
- s_axis_tready  out  1  high when the FIFO is not full.
- m_axis_tdata  out  DATA_WIDTH  head-of-FIFO data.
- m_axis_tvalid  out  1  high when the FIFO is not empty.
- m_axis_tlast  out  1  head-of-FIFO tlast.
- m_axis_tready  in  1  consumer ready.
- o_credit_add  out  CREDIT_WIDTH  credits returned this cycle; 0 when none.
- o_level  out  CREDIT_WIDTH  current FIFO occupancy.
- o_protocol_err  out  1  sticky; set when the sender presents a beat while the FIFO is full.
- i_clear_err  in  1  synchronous clear of o_protocol_err.

## Operation
- push = s_axis_tvalid & s_axis_tready; pop = m_axis_tvalid & m_axis_tready.
- FIFO: first-word fall-through, storing {tlast, tdata}. Read/write pointers are log2(DEPTH)+1 bits; pointers wrap naturally. full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
- Each cycle, level ← level + push − pop.
- Simultaneous push and pop:
  - Allowed at any non-full, non-empty level; level is unchanged.
  - When empty, only the push takes effect. There is no bypass.
  - When full, the push is blocked because tready is low.
- Credit return logic, evaluated every cycle on sum = pending + pop:
  - If sum ≥ RETURN_BATCH, or (sum > 0 and timer == RETURN_TIMEOUT−1): o_credit_add ← sum, pending ← 0, timer ← 0.
  - Else: o_credit_add ← 0, pending ← sum, timer ← (sum > 0) ? timer+1 : 0.
  - pending never exceeds RETURN_BATCH−1 after update, so it needs log2(RETURN_BATCH)+1 bits.
- Protocol error: s_axis_tvalid & full sets o_protocol_err. i_clear_err clears it; if set and clear coincide, set wins. No data is dropped, because the beat stays blocked by tready.
- Credits are returned only for popped beats. The sum of o_credit_add over time equals the total number of pops.

## Timing
- Reset values:
  - s_axis_tready = 1 (derived from empty).
  - m_axis_tvalid = 0; m_axis_tdata = 0; m_axis_tlast = 0.
  - o_credit_add = 0; o_level = 0; o_protocol_err = 0.
  - pending = 0; timer = 0; both pointers = 0.
- Latency:
  - A beat pushed in cycle N is visible on m_axis with tvalid high in cycle N+1.
  - s_axis_tready updates in cycle N+1 after the push that fills the FIFO.
- o_credit_add is registered. It is a single-cycle pulse appearing in the cycle after the triggering pop or timeout.
- s_axis_tready and m_axis_tvalid are decoded from registered pointers, with no combinational path from the inputs.
- Reset mid-operation empties the FIFO and discards pending credits. The sender is expected to re-initialise its credits.

## Structure
- Shared package flow_pkg holds the credit-width localparam and an elaboration-time check function for the parameter constraints (DEPTH power of two, RETURN_BATCH range, CREDIT_WIDTH sufficiency).
- Natural sub-module: sync_fifo_fwft (parameterised width/depth, providing full, empty and level). The credit return counter and timer live in the top module.

## Test plan
- Batch return: fill 4 beats, then pop 4 back-to-back → o_credit_add = 4 for exactly one cycle, one cycle after the 4th pop; 0 otherwise.
- Timeout return: push 1 beat, pop it, then idle → o_credit_add = 1 appears RETURN_TIMEOUT (32) cycles after the pop.
- Full/backpressure:
  - Push 16 beats with m_axis_tready = 0 → o_level = 16 and s_axis_tready = 0.
  - Hold tvalid for a 17th beat → o_protocol_err = 1 and remains set until i_clear_err.
- Simultaneous push/pop at level 8 for 20 cycles → o_level holds at 8, data order is preserved, tlast is carried intact, and total credits returned = 20.
- Empty push+pop: push into an empty FIFO with m_axis_tready = 1 → m_axis_tvalid first rises the next cycle and there is no pop in the push cycle.
- Reset mid-stream: with level 5 and pending 2, assert rst → o_level = 0, m_axis_tvalid = 0, o_credit_add = 0, and no late credit pulse after release.
